// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between I-cache fill, D-cache fill and D-cache
// store traffic: one transaction in flight, writes preferred with a bounded burst.
module mem_arbiter #(
  parameter int ADDR_WIDTH       = 64,
  parameter int DATA_WIDTH       = 64,
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int MAX_WR_BURST     = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_ic_read_req,
  input  logic [ADDR_WIDTH-1:0]       i_ic_read_address,
  output logic                        o_ic_read_done,
  output logic [CACHE_LINE_WIDTH-1:0] o_ic_cache_line,
  input  logic                        i_dc_read_req,
  input  logic [ADDR_WIDTH-1:0]       i_dc_read_address,
  output logic                        o_dc_read_done,
  output logic [CACHE_LINE_WIDTH-1:0] o_dc_cache_line,
  input  logic                        i_dc_write_valid,
  input  logic [ADDR_WIDTH-1:0]       i_dc_write_address,
  input  logic [DATA_WIDTH-1:0]       i_dc_write_data,
  input  logic [7:0]                  i_dc_write_strobe,
  output logic                        o_dc_write_done,
  output logic                        o_mem_read_req,
  output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
  input  logic                        i_mem_read_done,
  input  logic [CACHE_LINE_WIDTH-1:0] i_mem_cache_line,
  output logic                        o_mem_write_valid,
  output logic [ADDR_WIDTH-1:0]       o_mem_write_address,
  output logic [DATA_WIDTH-1:0]       o_mem_write_data,
  output logic [7:0]                  o_mem_write_strobe,
  input  logic                        i_mem_write_done
);

  localparam int CNT_W = $clog2(MAX_WR_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WR_BURST);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT
  } state_e;

  typedef enum logic {
    OWN_IC,
    OWN_DC
  } owner_e;

  state_e                state_q;
  owner_e                owner_q;
  owner_e                rr_last_q;
  logic [CNT_W-1:0]      wr_cnt_q;
  logic                  mem_read_req_q;
  logic [ADDR_WIDTH-1:0] mem_read_address_q;
  logic                  mem_write_valid_q;
  logic [ADDR_WIDTH-1:0] mem_write_address_q;
  logic [DATA_WIDTH-1:0] mem_write_data_q;
  logic [7:0]            mem_write_strobe_q;

  logic                  rd_pending;
  logic                  grant_wr;
  logic                  grant_rd;
  owner_e                owner_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic [CNT_W-1:0]      wr_cnt_d;

  // A write loses only once it has used up its burst while a read waits;
  // between two reads the one not served last wins.
  always_comb begin
    rd_pending = i_ic_read_req | i_dc_read_req;
    grant_wr   = i_dc_write_valid & (~rd_pending | (wr_cnt_q < MAX_CNT));
    grant_rd   = ~grant_wr & rd_pending;
    owner_d    = (i_dc_read_req & (~i_ic_read_req | (rr_last_q == OWN_IC))) ? OWN_DC : OWN_IC;
    rd_addr_d  = (owner_d == OWN_DC) ? i_dc_read_address : i_ic_read_address;
    wr_cnt_d   = (wr_cnt_q == MAX_CNT) ? wr_cnt_q : wr_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q             <= IDLE;
      owner_q             <= OWN_IC;
      rr_last_q           <= OWN_IC;
      wr_cnt_q            <= '0;
      mem_read_req_q      <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      mem_write_strobe_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            state_q             <= WR_REQ;
            mem_write_valid_q   <= 1'b1;
            mem_write_address_q <= i_dc_write_address;
            mem_write_data_q    <= i_dc_write_data;
            mem_write_strobe_q  <= i_dc_write_strobe;
            wr_cnt_q            <= wr_cnt_d;
          end else if (grant_rd) begin
            state_q            <= RD_REQ;
            mem_read_req_q     <= 1'b1;
            mem_read_address_q <= rd_addr_d;
            owner_q            <= owner_d;
            rr_last_q          <= owner_d;
            wr_cnt_q           <= '0;
          end
        end
        RD_REQ: begin
          mem_read_req_q <= 1'b0;
          state_q        <= RD_WAIT;
        end
        RD_WAIT: begin
          if (i_mem_read_done) state_q <= IDLE;
        end
        WR_REQ: begin
          mem_write_valid_q <= 1'b0;
          state_q           <= WR_WAIT;
        end
        WR_WAIT: begin
          if (i_mem_write_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Completions are forwarded only in the matching wait state, so stray
  // memory dones never reach a requester.
  always_comb begin
    o_ic_read_done  = (state_q == RD_WAIT) && (owner_q == OWN_IC) && i_mem_read_done;
    o_dc_read_done  = (state_q == RD_WAIT) && (owner_q == OWN_DC) && i_mem_read_done;
    o_dc_write_done = (state_q == WR_WAIT) && i_mem_write_done;
  end

  assign o_ic_cache_line     = i_mem_cache_line;
  assign o_dc_cache_line     = i_mem_cache_line;
  assign o_mem_read_req      = mem_read_req_q;
  assign o_mem_read_address  = mem_read_address_q;
  assign o_mem_write_valid   = mem_write_valid_q;
  assign o_mem_write_address = mem_write_address_q;
  assign o_mem_write_data    = mem_write_data_q;
  assign o_mem_write_strobe  = mem_write_strobe_q;

  a_rd_wr_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_mem_read_req && o_mem_write_valid));
  a_rd_req_pulse: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_mem_read_req |=> !o_mem_read_req);
  a_wr_valid_pulse: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_mem_write_valid |=> !o_mem_write_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run scored
// against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 256;
  localparam int MWB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ic_req = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic          ic_done;
  logic [LW-1:0] ic_line;
  logic          dc_req = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic          dc_done;
  logic [LW-1:0] dc_line;
  logic          wv = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [7:0]    wr_strb = '0;
  logic          wr_done;
  logic          mem_rreq;
  logic [AW-1:0] mem_raddr;
  logic          mem_rdone = 1'b0;
  logic [LW-1:0] mem_line = '0;
  logic          mem_wvalid;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wstrb;
  logic          mem_wdone = 1'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CACHE_LINE_WIDTH(LW), .MAX_WR_BURST(MWB)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ic_read_req(ic_req), .i_ic_read_address(ic_addr),
    .o_ic_read_done(ic_done), .o_ic_cache_line(ic_line),
    .i_dc_read_req(dc_req), .i_dc_read_address(dc_addr),
    .o_dc_read_done(dc_done), .o_dc_cache_line(dc_line),
    .i_dc_write_valid(wv), .i_dc_write_address(wr_addr),
    .i_dc_write_data(wr_data), .i_dc_write_strobe(wr_strb),
    .o_dc_write_done(wr_done),
    .o_mem_read_req(mem_rreq), .o_mem_read_address(mem_raddr),
    .i_mem_read_done(mem_rdone), .i_mem_cache_line(mem_line),
    .o_mem_write_valid(mem_wvalid), .o_mem_write_address(mem_waddr),
    .o_mem_write_data(mem_wdata), .o_mem_write_strobe(mem_wstrb),
    .i_mem_write_done(mem_wdone)
  );

  initial begin
    #200us;
    $display("[TB] FAIL global_timeout: simulation did not finish within 200us");
    $fatal(1, "[TB] timeout");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for the next memory request, answers it one cycle later with a
  // one-cycle done and reports what was seen; the caller judges it.
  task automatic serveOne(input logic [LW-1:0] line, output bit got, output bit isWr,
                          output logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [7:0] strb, output bit both, output bit held,
                          output int waitCyc, output logic icD, output logic dcD,
                          output logic wrD, output logic [LW-1:0] icL, output logic [LW-1:0] dcL);
    got = 0; isWr = 0; addr = '0; data = '0; strb = '0; both = 0; held = 0; waitCyc = 0;
    icD = 0; dcD = 0; wrD = 0; icL = '0; dcL = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      waitCyc++;
      if (mem_rreq && mem_wvalid) both = 1;
      if (mem_rreq || mem_wvalid) begin
        got  = 1;
        isWr = mem_wvalid;
        addr = mem_wvalid ? mem_waddr : mem_raddr;
        data = mem_wdata;
        strb = mem_wstrb;
      end
    end
    if (got) begin
      @(posedge clk); #1;
      held = mem_rreq || mem_wvalid;
      mem_line = line;
      if (isWr) mem_wdone = 1'b1; else mem_rdone = 1'b1;
      @(negedge clk);
      icD = ic_done; dcD = dc_done; wrD = wr_done; icL = ic_line; dcL = dc_line;
      @(posedge clk); #1;
      mem_rdone = 1'b0;
      mem_wdone = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({mem_rreq, mem_wvalid, ic_done, dc_done, wr_done} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b want 00000", {mem_rreq, mem_wvalid, ic_done, dc_done, wr_done});
    end
    compared++;
    if ({mem_raddr, mem_waddr, mem_wdata, mem_wstrb} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: raddr %h waddr %h wdata %h strb %h want all 0", mem_raddr, mem_waddr, mem_wdata, mem_wstrb);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    compared++;
    if ({mem_rreq, mem_wvalid} !== 2'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_idle: got %b want 00", {mem_rreq, mem_wvalid});
    end
  endtask

  task automatic test_single_ic_fill();
    bit got, isWr, both, held; int wc;
    logic [AW-1:0] a; logic [DW-1:0] d; logic [7:0] s;
    logic icD, dcD, wrD; logic [LW-1:0] icL, dcL;
    logic [LW-1:0] lineA;
    lineA = {16{16'hAAAA}};
    ic_req = 1'b1; ic_addr = 64'h40;
    serveOne(lineA, got, isWr, a, d, s, both, held, wc, icD, dcD, wrD, icL, dcL);
    ic_req = 1'b0;
    compared++;
    if (!got || isWr || a !== 64'h40) begin
      mismatched++;
      $display("[TB] FAIL fill_req: got=%0d wr=%0d addr %h want read at 40", got, isWr, a);
    end
    compared++;
    if (wc != 1 || held) begin
      mismatched++;
      $display("[TB] FAIL fill_timing: wait %0d held %0d want 1 and 0", wc, held);
    end
    compared++;
    if ({icD, dcD, wrD} !== 3'b100 || icL !== lineA) begin
      mismatched++;
      $display("[TB] FAIL fill_done: ic/dc/wr %b line %h want 100 line %h", {icD, dcD, wrD}, icL, lineA);
    end
    idle(2);
  endtask

  task automatic test_round_robin();
    bit got, isWr, both, held; int wc;
    logic [AW-1:0] a; logic [DW-1:0] d; logic [7:0] s;
    logic icD, dcD, wrD; logic [LW-1:0] icL, dcL;
    logic [AW-1:0] expAddr [4];
    bit expDc [4];
    expAddr = '{64'h200, 64'h100, 64'h200, 64'h100};
    expDc = '{1, 0, 1, 0};
    ic_addr = 64'h100; dc_addr = 64'h200;
    ic_req = 1'b1; dc_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serveOne(LW'(k + 1), got, isWr, a, d, s, both, held, wc, icD, dcD, wrD, icL, dcL);
      compared++;
      if (!got || isWr || a !== expAddr[k]) begin
        mismatched++;
        $display("[TB] FAIL rr_grant%0d: got=%0d wr=%0d addr %h want read at %h", k, got, isWr, a, expAddr[k]);
      end
      compared++;
      if (icD !== !expDc[k] || dcD !== expDc[k]) begin
        mismatched++;
        $display("[TB] FAIL rr_done%0d: ic %b dc %b want dc=%0d", k, icD, dcD, expDc[k]);
      end
    end
    ic_req = 1'b0; dc_req = 1'b0;
    idle(2);
  endtask

  task automatic test_write_burst();
    bit got, isWr, both, held; int wc;
    logic [AW-1:0] a; logic [DW-1:0] d; logic [7:0] s;
    logic icD, dcD, wrD; logic [LW-1:0] icL, dcL;
    bit expWr [6];
    expWr = '{1, 1, 1, 1, 0, 1};
    wv = 1'b1; wr_addr = 64'h300; wr_data = {$urandom, $urandom}; wr_strb = 8'hFF;
    dc_req = 1'b1; dc_addr = 64'h280;
    for (int k = 0; k < 6; k++) begin
      serveOne('0, got, isWr, a, d, s, both, held, wc, icD, dcD, wrD, icL, dcL);
      compared++;
      if (!got || isWr !== expWr[k] || a !== (expWr[k] ? 64'h300 : 64'h280)) begin
        mismatched++;
        $display("[TB] FAIL burst_grant%0d: got=%0d wr=%0d addr %h want wr=%0d", k, got, isWr, a, expWr[k]);
      end
      compared++;
      if (both || wrD !== expWr[k] || dcD !== !expWr[k]) begin
        mismatched++;
        $display("[TB] FAIL burst_done%0d: both %0d wrdone %b dcdone %b want wr=%0d", k, both, wrD, dcD, expWr[k]);
      end
    end
    wv = 1'b0; dc_req = 1'b0;
    idle(2);
  endtask

  task automatic test_write_fields();
    bit got, isWr, both, held; int wc;
    logic [AW-1:0] a; logic [DW-1:0] d; logic [7:0] s;
    logic icD, dcD, wrD; logic [LW-1:0] icL, dcL;
    wv = 1'b1; wr_addr = 64'h18; wr_data = 64'h1122334455667788; wr_strb = 8'h0F;
    serveOne('0, got, isWr, a, d, s, both, held, wc, icD, dcD, wrD, icL, dcL);
    wv = 1'b0;
    compared++;
    if (!got || !isWr || a !== 64'h18 || d !== 64'h1122334455667788 || s !== 8'h0F) begin
      mismatched++;
      $display("[TB] FAIL wfield_values: got=%0d wr=%0d addr %h data %h strb %h want 18/1122334455667788/0f", got, isWr, a, d, s);
    end
    compared++;
    if (held || wrD !== 1'b1 || icD !== 1'b0 || dcD !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wfield_done: held %0d wr %b ic %b dc %b want 0 1 0 0", held, wrD, icD, dcD);
    end
    idle(1);
    wv = 1'b1; wr_addr = 64'h20; wr_strb = 8'h00;
    serveOne('0, got, isWr, a, d, s, both, held, wc, icD, dcD, wrD, icL, dcL);
    wv = 1'b0;
    compared++;
    if (!got || !isWr || s !== 8'h00 || a !== 64'h20 || wrD !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wfield_zero_strobe: got=%0d wr=%0d strb %h addr %h done %b want write 20 strb 0 done 1", got, isWr, s, a, wrD);
    end
    idle(2);
  endtask

  task automatic test_spurious_done();
    logic [LW-1:0] l;
    mem_rdone = 1'b1; mem_wdone = 1'b1;
    @(negedge clk);
    compared++;
    if ({ic_done, dc_done, wr_done} !== 3'b0) begin
      mismatched++;
      $display("[TB] FAIL spur_idle_done: got %b want 000", {ic_done, dc_done, wr_done});
    end
    @(posedge clk); #1;
    mem_rdone = 1'b0; mem_wdone = 1'b0;
    idle(1);
    compared++;
    if ({mem_rreq, mem_wvalid} !== 2'b0) begin
      mismatched++;
      $display("[TB] FAIL spur_idle_req: got %b want 00", {mem_rreq, mem_wvalid});
    end
    dc_req = 1'b1; dc_addr = 64'h500;
    @(posedge clk); #1;
    compared++;
    if (mem_rreq !== 1'b1 || mem_raddr !== 64'h500) begin
      mismatched++;
      $display("[TB] FAIL spur_rd_req: req %b addr %h want 1 500", mem_rreq, mem_raddr);
    end
    @(posedge clk); #1;
    mem_wdone = 1'b1;
    @(negedge clk);
    compared++;
    if ({ic_done, dc_done, wr_done} !== 3'b0) begin
      mismatched++;
      $display("[TB] FAIL spur_wrong_done: got %b want 000", {ic_done, dc_done, wr_done});
    end
    @(posedge clk); #1;
    mem_wdone = 1'b0;
    l = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    mem_line = l; mem_rdone = 1'b1;
    @(negedge clk);
    compared++;
    if (dc_done !== 1'b1 || ic_done !== 1'b0 || dc_line !== l) begin
      mismatched++;
      $display("[TB] FAIL spur_still_waiting: dc %b ic %b line %h want 1 0 %h", dc_done, ic_done, dc_line, l);
    end
    @(posedge clk); #1;
    mem_rdone = 1'b0; dc_req = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_mid();
    bit got, isWr, both, held; int wc;
    logic [AW-1:0] a; logic [DW-1:0] d; logic [7:0] s;
    logic icD, dcD, wrD; logic [LW-1:0] icL, dcL;
    ic_req = 1'b1; ic_addr = 64'h600;
    @(posedge clk); #1;
    compared++;
    if (mem_rreq !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rmid_req: got %b want 1", mem_rreq);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({mem_rreq, mem_wvalid, ic_done, dc_done, wr_done} !== 5'b0 || {mem_raddr, mem_waddr, mem_wdata, mem_wstrb} !== '0) begin
      mismatched++;
      $display("[TB] FAIL rmid_async: ctrl %b raddr %h want all 0", {mem_rreq, mem_wvalid, ic_done, dc_done, wr_done}, mem_raddr);
    end
    ic_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rdone = 1'b1;
    @(negedge clk);
    compared++;
    if ({ic_done, dc_done} !== 2'b0) begin
      mismatched++;
      $display("[TB] FAIL rmid_late_done: got %b want 00", {ic_done, dc_done});
    end
    @(posedge clk); #1;
    mem_rdone = 1'b0;
    compared++;
    if ({mem_rreq, mem_wvalid} !== 2'b0) begin
      mismatched++;
      $display("[TB] FAIL rmid_no_req: got %b want 00", {mem_rreq, mem_wvalid});
    end
    ic_req = 1'b1; ic_addr = 64'h640;
    serveOne({8{32'h5A5A1234}}, got, isWr, a, d, s, both, held, wc, icD, dcD, wrD, icL, dcL);
    ic_req = 1'b0;
    compared++;
    if (!got || isWr || a !== 64'h640 || icD !== 1'b1 || icL !== {8{32'h5A5A1234}}) begin
      mismatched++;
      $display("[TB] FAIL rmid_rerequest: got=%0d wr=%0d addr %h done %b want read 640 done 1", got, isWr, a, icD);
    end
    idle(2);
  endtask

  task automatic test_random();
    bit busy = 0, ownWr = 0, ownDc = 0, lastDc = 0, doneDrv = 0, prevReq = 0, grantNow;
    bit icJust = 0, dcJust = 0, wrJust = 0, anyRd, expWr, expDc, expIcD, expDcD, expWrD;
    int waitCnt = 0, wrStreak = 0, stall = 0, grants = 0;
    logic [LW-1:0] l = '0;
    logic [AW-1:0] expAddr;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(posedge clk); #1;
      grantNow = mem_rreq || mem_wvalid;
      compared++;
      if (mem_rreq && mem_wvalid) begin
        mismatched++;
        $display("[TB] FAIL rnd_exclusive: cycle %0d both read and write requested", cyc);
      end
      if (grantNow) begin
        compared++;
        if (busy || prevReq) begin
          mismatched++;
          $display("[TB] FAIL rnd_overlap: cycle %0d request while busy=%0d prev=%0d, want neither", cyc, busy, prevReq);
        end
        anyRd = ic_req || dc_req;
        expWr = wv && (!anyRd || wrStreak < MWB);
        expDc = dc_req && (!ic_req || !lastDc);
        compared++;
        if (mem_wvalid !== expWr) begin
          mismatched++;
          $display("[TB] FAIL rnd_kind: cycle %0d write %b want %0d", cyc, mem_wvalid, expWr);
        end
        if (expWr) begin
          wrStreak++;
          compared++;
          if (mem_waddr !== wr_addr || mem_wdata !== wr_data || mem_wstrb !== wr_strb) begin
            mismatched++;
            $display("[TB] FAIL rnd_wfields: addr %h data %h strb %h want %h %h %h", mem_waddr, mem_wdata, mem_wstrb, wr_addr, wr_data, wr_strb);
          end
        end else begin
          expAddr = expDc ? dc_addr : ic_addr;
          lastDc = expDc;
          wrStreak = 0;
          compared++;
          if (mem_raddr !== expAddr) begin
            mismatched++;
            $display("[TB] FAIL rnd_raddr: cycle %0d addr %h want %h", cyc, mem_raddr, expAddr);
          end
        end
        busy = 1; ownWr = expWr; ownDc = expDc;
        waitCnt = $urandom_range(1, 3);
        grants++;
        stall = 0;
      end else if (!busy && (ic_req || dc_req || wv)) begin
        stall++;
        compared++;
        if (stall == 3) begin
          mismatched++;
          $display("[TB] FAIL rnd_stall: cycle %0d no grant for %0d cycles, want at most 2", cyc, stall);
        end
      end else begin
        stall = 0;
      end
      prevReq = grantNow;
      mem_rdone = 1'b0; mem_wdone = 1'b0; doneDrv = 0;
      if (busy && !grantNow) begin
        waitCnt--;
        if (waitCnt == 0) begin
          doneDrv = 1;
          l = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
          mem_line = l;
          if (ownWr) mem_wdone = 1'b1; else mem_rdone = 1'b1;
        end else if ($urandom_range(0, 3) == 0) begin
          if (ownWr) mem_rdone = 1'b1; else mem_wdone = 1'b1;
        end
      end else if (!busy && $urandom_range(0, 7) == 0) begin
        mem_rdone = 1'b1; mem_wdone = 1'b1;
      end
      if (icJust) begin ic_req = 1'b0; icJust = 0; end
      else if (!ic_req && $urandom_range(0, 3) == 0) begin ic_req = 1'b1; ic_addr = {$urandom, $urandom}; end
      if (dcJust) begin dc_req = 1'b0; dcJust = 0; end
      else if (!dc_req && $urandom_range(0, 3) == 0) begin dc_req = 1'b1; dc_addr = {$urandom, $urandom}; end
      if (wrJust) begin wv = 1'b0; wrJust = 0; end
      else if (!wv && $urandom_range(0, 2) == 0) begin
        wv = 1'b1; wr_addr = {$urandom, $urandom}; wr_data = {$urandom, $urandom};
        wr_strb = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      expIcD = doneDrv && !ownWr && !ownDc;
      expDcD = doneDrv && !ownWr && ownDc;
      expWrD = doneDrv && ownWr;
      compared++;
      if (ic_done !== expIcD || dc_done !== expDcD || wr_done !== expWrD) begin
        mismatched++;
        $display("[TB] FAIL rnd_done: cycle %0d ic/dc/wr %b%b%b want %0d%0d%0d", cyc, ic_done, dc_done, wr_done, expIcD, expDcD, expWrD);
      end
      if (doneDrv) begin
        if (!ownWr) begin
          compared++;
          if ((ownDc ? dc_line : ic_line) !== l) begin
            mismatched++;
            $display("[TB] FAIL rnd_line: cycle %0d line %h want %h", cyc, ownDc ? dc_line : ic_line, l);
          end
        end
        busy = 0;
        if (ownWr) wrJust = 1; else if (ownDc) dcJust = 1; else icJust = 1;
      end
    end
    compared++;
    if (grants < 100) begin
      mismatched++;
      $display("[TB] FAIL rnd_progress: %0d grants, want at least 100", grants);
    end
    @(posedge clk); #1;
    ic_req = 1'b0; dc_req = 1'b0; wv = 1'b0; mem_rdone = 1'b0; mem_wdone = 1'b0;
    idle(8);
  endtask

  initial begin
    test_reset();
    test_single_ic_fill();
    test_round_robin();
    test_write_burst();
    test_write_fields();
    test_spurious_done();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-ported main memory between three requesters: I-cache line fill, D-cache line fill, and D-cache write-through store.
- Sits between the L1 caches and the memory's read channel (256-bit line) and write channel (64-bit, byte strobes).
- Guarantees one memory transaction in flight at a time and never asserts read request and write valid together.
- Policy: writes are preferred, with a bounded write burst; the two read requesters are round-robin.

Parameters:
- ADDR_WIDTH, 64, address width on all ports.
- DATA_WIDTH, 64, write data width.
- CACHE_LINE_WIDTH, 256, read line width.
- MAX_WR_BURST, 4, maximum consecutive write grants while any read is pending (≥1).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ic_read_req  in  1  I-cache fill request; held until done.
- i_ic_read_address  in  ADDR_WIDTH  I-cache fill address.
- o_ic_read_done  out  1  one-cycle fill completion to I-cache.
- o_ic_cache_line  out  CACHE_LINE_WIDTH  fill data, valid with o_ic_read_done.
- i_dc_read_req  in  1  D-cache fill request; held until done.
- i_dc_read_address  in  ADDR_WIDTH  D-cache fill address.
- o_dc_read_done  out  1  one-cycle fill completion to D-cache.
- o_dc_cache_line  out  CACHE_LINE_WIDTH  fill data, valid with o_dc_read_done.
- i_dc_write_valid  in  1  store request; held until done.
- i_dc_write_address  in  ADDR_WIDTH  store address.
- i_dc_write_data  in  DATA_WIDTH  store data.
- i_dc_write_strobe  in  8  byte enables.
- o_dc_write_done  out  1  one-cycle store completion.
- o_mem_read_req  out  1  to memory.
- o_mem_read_address  out  ADDR_WIDTH  to memory.
- i_mem_read_done  in  1  from memory.
- i_mem_cache_line  in  CACHE_LINE_WIDTH  from memory.
- o_mem_write_valid  out  1  to memory.
- o_mem_write_address  out  ADDR_WIDTH  to memory.
- o_mem_write_data  out  DATA_WIDTH  to memory.
- o_mem_write_strobe  out  8  to memory.
- o_mem_write_done_in is not a port; the memory write completion arrives on i_mem_write_done  in  1.

Behaviour:
- Reset:
  - One clock domain; reset is asynchronous and active-low.
  - All o_mem_* outputs reset to 0; FSM goes to IDLE; rr_last=IC; wr_cnt=0.
  - Requester done outputs are 0 in reset and in IDLE.
- FSM states:
  - IDLE: arbitrate.
  - RD_REQ / WR_REQ: memory request asserted for exactly one cycle.
  - RD_WAIT / WR_WAIT: wait for the memory done.
- Arbitration in IDLE (inputs sampled at the clock edge):
  - Write pending and (no read pending, or wr_cnt<MAX_WR_BURST): grant write.
  - Otherwise, if any read is pending: grant a read.
    - If both reads are pending, grant the one not equal to rr_last.
    - Update rr_last to the granted read and clear wr_cnt.
  - A write grant increments wr_cnt, saturating at MAX_WR_BURST.
  - With no read pending, writes continue indefinitely.
- Grant registers the granted address, data and strobe into the o_mem_* outputs and latches the owner. Next state is RD_REQ or WR_REQ.
- RD_REQ: o_mem_read_req=1 for one cycle, then RD_WAIT with o_mem_read_req=0.
- RD_WAIT:
  - When i_mem_read_done=1, the owner's done=1 in the same cycle (combinational, gated by state and owner).
  - The owner's line = i_mem_cache_line; the non-owner's done is 0.
  - Next state is IDLE.
- WR_REQ / WR_WAIT: same pattern using o_mem_write_valid, i_mem_write_done and o_dc_write_done.
- Latency: request sampled at edge E → memory request in cycle E+1 → done to requester in cycle E+2 (with memory's 1-cycle response).
  - Back-to-back grants: IDLE occupies 1 cycle, so throughput is 1 transaction per 3 cycles.
- Requesters must deassert their req/valid in the cycle after their done. A req still high in IDLE is treated as a new request.
- Address, data and strobe are forwarded unmodified. Strobe=0 is still issued and completed.
- o_ic_cache_line and o_dc_cache_line are driven from i_mem_cache_line at all times; they are only meaningful with done.
- Memory done received in IDLE, REQ states, or the wrong WAIT state is ignored and never forwarded.
- Memory done never arrives: the FSM stays in WAIT (no timeout). Reset is the only exit.
- Reset mid-transaction: immediate return to IDLE. A late memory done after reset is ignored and the requester must re-request.
- Requester inputs that change while not granted have no effect until the next IDLE arbitration.

Test Plan:
- Single IC fill at address 0x40 → o_mem_read_req high exactly one cycle with address 0x40. Memory line 0xAAAA…; o_ic_read_done pulses 2 cycles after req sampled, carrying that line. o_dc_read_done stays 0.
- IC and DC reads held continuously for 4 transactions → grants alternate DC, IC, DC, IC (rr_last=IC after reset).
- Write valid continuous plus DC read pending, MAX_WR_BURST=4 → 4 write grants, then 1 read grant, then writes resume. o_mem_read_req and o_mem_write_valid are never high together.
- Write address 0x18, data 0x1122334455667788, strobe 0x0F → o_mem_write_* carry exactly these values for one cycle; o_dc_write_done pulses on i_mem_write_done.
- Spurious i_mem_read_done in IDLE, and i_mem_write_done during RD_WAIT → no requester done asserted, and the FSM state is unchanged.
- Assert i_rst_n=0 during RD_WAIT → all outputs 0 asynchronously. A memory done one cycle after release is ignored, and the next request is served normally.
